// File: rtl/cfa_cross_window_gen_if.sv
// Pixel-stream in / cross-window out bundle for cfa_cross_window_gen.
// master = pixel source / window consumer, slave = the window generator.
interface cfa_cross_window_gen_if #(
  parameter int unsigned PixelBitWidth = 12,
  parameter int unsigned Cw            = 7
);
  logic [PixelBitWidth-1:0] pix_in;
  logic                     pix_valid;
  logic                     sof;

  logic [PixelBitWidth-1:0] p_m2_p0;
  logic [PixelBitWidth-1:0] p_m1_p0;
  logic [PixelBitWidth-1:0] p_p0_m2;
  logic [PixelBitWidth-1:0] p_p0_m1;
  logic [PixelBitWidth-1:0] p_p0_p0;
  logic [PixelBitWidth-1:0] p_p0_p1;
  logic [PixelBitWidth-1:0] p_p0_p2;
  logic [PixelBitWidth-1:0] p_p1_p0;
  logic [PixelBitWidth-1:0] p_p2_p0;
  logic                     win_valid;
  logic [Cw-1:0]            win_x;
  logic [Cw-1:0]            win_y;
  logic                     frame_done;
  logic                     frame_err;

  modport master (
    output pix_in, pix_valid, sof,
    input  p_m2_p0, p_m1_p0, p_p0_m2, p_p0_m1, p_p0_p0, p_p0_p1, p_p0_p2, p_p1_p0, p_p2_p0,
    input  win_valid, win_x, win_y, frame_done, frame_err
  );

  modport slave (
    input  pix_in, pix_valid, sof,
    output p_m2_p0, p_m1_p0, p_p0_m2, p_p0_m1, p_p0_p0, p_p0_p1, p_p0_p2, p_p1_p0, p_p2_p0,
    output win_valid, win_x, win_y, frame_done, frame_err
  );
endinterface

// File: rtl/cfa_cross_window_gen.sv
// Raster Bayer stream -> 9-tap cross neighbourhood (5 rows x 5 cols through the centre).
// Four line buffers give the column above the current pixel; a shift register holds the
// centre row; the vertical stack is delayed two accepts so both arms meet at column c-2.
module cfa_cross_window_gen #(
  parameter int unsigned PixelBitWidth = 12,
  parameter int unsigned ImgWidth      = 64,
  parameter int unsigned ImgHeight     = 48,
  parameter int unsigned Cw            = 7
) (
  input logic                clk,
  input logic                rst_n,
  cfa_cross_window_gen_if.slave stream_if
);

  localparam int unsigned   AddrW   = (ImgWidth > 1) ? $clog2(ImgWidth) : 1;
  localparam logic [Cw-1:0] LastCol = Cw'(ImgWidth - 1);
  localparam logic [Cw-1:0] LastRow = Cw'(ImgHeight - 1);
  localparam logic [Cw-1:0] Edge    = Cw'(4);
  localparam logic [Cw-1:0] Half    = Cw'(2);

  typedef enum logic [1:0] {StIdle, StActive, StDone} state_e;

  typedef logic [PixelBitWidth-1:0] pix_t;

  state_e        state_q, state_d;
  logic [Cw-1:0] col_q, col_d, row_q, row_d;
  logic [Cw-1:0] cur_col, cur_row;
  logic          restart, accept, last_pix, win_hit;
  logic [AddrW-1:0] addr;

  // Line buffer k holds row r-1-k; RAM contents are never reset.
  pix_t lb_q [4][ImgWidth];
  pix_t lb_rd [4];

  // Vertical stack, index 0..3 = rows r-4, r-3, r-1, r (row r-2 comes from hsr).
  logic [3:0][PixelBitWidth-1:0] stack, vd1_q, vd2_q;
  // Centre row history: index 0 = col c-1 ... 3 = col c-4.
  logic [3:0][PixelBitWidth-1:0] hsr_q;

  logic [8:0][PixelBitWidth-1:0] taps_q, taps_d;
  logic          win_valid_q;
  logic [Cw-1:0] win_x_q, win_y_q;
  logic          frame_err_q;

  // Accept decode, position of the current sample and next counter/state values.
  always_comb begin
    restart  = stream_if.pix_valid & stream_if.sof;
    accept   = stream_if.pix_valid & ((state_q == StActive) | stream_if.sof);
    cur_col  = restart ? '0 : col_q;
    cur_row  = restart ? '0 : row_q;
    last_pix = accept & (cur_col == LastCol) & (cur_row == LastRow);
    win_hit  = accept & (cur_row >= Edge) & (cur_col >= Edge);
    addr     = cur_col[AddrW-1:0];
    col_d    = col_q;
    row_d    = row_q;
    state_d  = state_q;
    if (accept) begin
      if (cur_col == LastCol) begin
        col_d = '0;
        row_d = (cur_row == LastRow) ? '0 : cur_row + Cw'(1);
      end else begin
        col_d = cur_col + Cw'(1);
        row_d = cur_row;
      end
    end
    unique case (state_q)
      StIdle, StDone: state_d = accept ? StActive : StIdle;
      StActive:       state_d = last_pix ? StDone : StActive;
      default:        state_d = StIdle;
    endcase
  end

  // Line-buffer reads at the current column and the assembled window.
  always_comb begin
    for (int k = 0; k < 4; k++) lb_rd[k] = lb_q[k][addr];
    stack  = {stream_if.pix_in, lb_rd[0], lb_rd[2], lb_rd[3]};
    taps_d = {vd2_q[0], vd2_q[1],               // rows -2, -1
              hsr_q[3], hsr_q[2], hsr_q[1], hsr_q[0], lb_rd[1],  // cols -2..+2
              vd2_q[2], vd2_q[3]};              // rows +1, +2
  end

  // Line-buffer column cascade on each accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_q[0][addr] <= stream_if.pix_in;
      lb_q[1][addr] <= lb_rd[0];
      lb_q[2][addr] <= lb_rd[1];
      lb_q[3][addr] <= lb_rd[2];
    end
  end

  // Control state, history registers and registered window outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      col_q       <= '0;
      row_q       <= '0;
      hsr_q       <= '0;
      vd1_q       <= '0;
      vd2_q       <= '0;
      taps_q      <= '0;
      win_valid_q <= 1'b0;
      win_x_q     <= '0;
      win_y_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= win_hit;
      frame_err_q <= restart & (state_q == StActive);
      if (accept) begin
        hsr_q <= {hsr_q[2:0], lb_rd[1]};
        vd1_q <= stack;
        vd2_q <= vd1_q;
      end
      // Taps hold between windows.
      if (win_hit) begin
        taps_q  <= taps_d;
        win_x_q <= cur_col - Half;
        win_y_q <= cur_row - Half;
      end
    end
  end

  // Output mapping.
  always_comb begin
    stream_if.p_m2_p0    = taps_q[8];
    stream_if.p_m1_p0    = taps_q[7];
    stream_if.p_p0_m2    = taps_q[6];
    stream_if.p_p0_m1    = taps_q[5];
    stream_if.p_p0_p0    = taps_q[4];
    stream_if.p_p0_p1    = taps_q[3];
    stream_if.p_p0_p2    = taps_q[2];
    stream_if.p_p1_p0    = taps_q[1];
    stream_if.p_p2_p0    = taps_q[0];
    stream_if.win_valid  = win_valid_q;
    stream_if.win_x      = win_x_q;
    stream_if.win_y      = win_y_q;
    stream_if.frame_done = (state_q == StDone);
    stream_if.frame_err  = frame_err_q;
  end

endmodule
